// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin two-port arbiter and sequencer for a single-port
// synchronous memory; one latched access at a time, IDLE -> ACCESS -> RESP.
module mem_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W+1:0] addr0,
    input  logic [ADDR_W+1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_last;
    logic              r_gnt;
    logic              r_op_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              w_grant;
    logic              w_pick;
    logic              w_unused;

    assign w_unused = &{1'b0, addr0[1:0], addr1[1:0]};

    // Port 1 wins when alone, or on a tie when port 0 was served last.
    always_comb begin
        w_pick  = req1 && (!req0 || !r_last);
        w_grant = (r_state == IDLE) && (req0 || req1);
        w_next  = w_grant ? ACCESS : (r_state == ACCESS) ? RESP : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
            r_gnt   <= 1'b0;
            r_op_we <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_next;
            if (w_grant) begin
                r_gnt   <= w_pick;
                r_op_we <= w_pick ? we1 : we0;
                r_addr  <= w_pick ? addr1[ADDR_W+1:2] : addr0[ADDR_W+1:2];
                r_wdata <= w_pick ? wdata1 : wdata0;
            end
            if (r_state == ACCESS)
                r_last <= r_gnt;
        end
    end

    assign mem_read  = (r_state == ACCESS) && !r_op_we;
    assign mem_write = (r_state == ACCESS) && r_op_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign ack0      = (r_state == RESP) && !r_gnt;
    assign ack1      = (r_state == RESP) && r_gnt;
    assign busy      = r_state != IDLE;
    assign rdata     = mem_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table, hand-written corner sequences and a
// randomized run checked against a transaction-level timing/memory model.
module tb_mem_arbiter;
    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [AW+1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          ack0, ack1, busy, mem_read, mem_write;
    logic [DW-1:0] rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0;
    logic [DW-1:0] mem [1024];

    int total = 0;
    int bad = 0;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port memory with registered read data.
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr] <= mem_wdata;
        if (mem_read) mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic p, input logic r, input logic we, input logic [AW+1:0] a, input logic [DW-1:0] d);
        if (p) begin
            req1 = r; we1 = we; addr1 = a; wdata1 = d;
        end else begin
            req0 = r; we0 = we; addr0 = a; wdata0 = d;
        end
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic          port;
        logic          we;
        logic [AW+1:0] addr;
        logic [DW-1:0] wdata;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    vec_t vt[7];

    // Random-phase model state
    logic          p_act [2];
    logic          p_we  [2];
    logic [AW+1:0] p_addr[2];
    logic [DW-1:0] p_data[2];
    logic [DW-1:0] ref_mem[16];
    logic          known[16];

    initial begin
        vt[0] = '{1'b0, 1'b1, 12'h008, 32'hDEADBEEF, 10'd2,    32'h0};
        vt[1] = '{1'b0, 1'b0, 12'h008, 32'h0,        10'd2,    32'hDEADBEEF};
        vt[2] = '{1'b1, 1'b1, 12'hFFC, 32'h12345678, 10'd1023, 32'h0};
        vt[3] = '{1'b1, 1'b0, 12'hFFC, 32'h0,        10'd1023, 32'h12345678};
        vt[4] = '{1'b0, 1'b0, 12'h00B, 32'h0,        10'd2,    32'hDEADBEEF};
        vt[5] = '{1'b0, 1'b1, 12'h010, 32'hA5A5A5A5, 10'd4,    32'h0};
        vt[6] = '{1'b1, 1'b0, 12'h013, 32'h0,        10'd4,    32'hA5A5A5A5};

        // Reset state
        tick();
        tick();
        chk("rst_ack0", ack0, 0);
        chk("rst_ack1", ack1, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        rst_n = 1'b1;
        tick();

        // Vector table: one isolated access per record
        foreach (vt[i]) begin
            drive(vt[i].port, 1'b1, vt[i].we, vt[i].addr, vt[i].wdata);
            tick();
            chk($sformatf("v%0d_mem_read", i), mem_read, !vt[i].we);
            chk($sformatf("v%0d_mem_write", i), mem_write, vt[i].we);
            chk($sformatf("v%0d_mem_addr", i), mem_addr, vt[i].exp_addr);
            chk($sformatf("v%0d_busy", i), busy, 1);
            chk($sformatf("v%0d_early_ack", i), {ack0, ack1}, 0);
            if (vt[i].we) chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vt[i].wdata);
            tick();
            chk($sformatf("v%0d_ack", i), {ack1, ack0}, vt[i].port ? 2'b10 : 2'b01);
            chk($sformatf("v%0d_strobes_off", i), {mem_read, mem_write}, 0);
            if (!vt[i].we) chk($sformatf("v%0d_rdata", i), rdata, vt[i].exp_rdata);
            drive(vt[i].port, 1'b0, 1'b0, '0, '0);
            tick();
            chk($sformatf("v%0d_idle", i), {busy, ack0, ack1}, 0);
        end

        // Tie held continuously after reset: grants 0,1,0,1 every 3 cycles
        reset_pulse();
        drive(1'b0, 1'b1, 1'b0, 12'h008, '0);
        drive(1'b1, 1'b1, 1'b0, 12'hFFC, '0);
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk($sformatf("tie_ack0_c%0d", k), ack0, (k == 2 || k == 8));
            chk($sformatf("tie_ack1_c%0d", k), ack1, (k == 5 || k == 11));
            if (ack0) chk($sformatf("tie_rdata0_c%0d", k), rdata, 32'hDEADBEEF);
            if (ack1) chk($sformatf("tie_rdata1_c%0d", k), rdata, 32'h12345678);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        tick();

        // Late arrival during port 0's ACCESS cycle
        drive(1'b0, 1'b1, 1'b0, 12'h00B, '0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 12'hFFC, '0);
        tick();
        chk("late_ack0", {ack1, ack0}, 2'b01);
        chk("late_rdata0", rdata, 32'hDEADBEEF);
        req0 = 1'b0;
        tick();
        chk("late_gap3", {ack1, ack0}, 0);
        tick();
        chk("late_gap4", {ack1, ack0}, 0);
        tick();
        chk("late_ack1", {ack1, ack0}, 2'b10);
        chk("late_rdata1", rdata, 32'h12345678);
        req1 = 1'b0;
        tick();

        // Reset during RESP abandons the ack; pending req1 served if req0 low
        drive(1'b0, 1'b1, 1'b0, 12'h008, '0);
        drive(1'b1, 1'b1, 1'b0, 12'hFFC, '0);
        tick();
        tick();
        chk("mrst_ack0_before", ack0, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("mrst_ack_drop", {ack0, ack1}, 0);
        chk("mrst_busy", busy, 0);
        req0 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        chk("mrst_p1_first", {ack1, ack0}, 2'b10);
        req1 = 1'b0;
        tick();
        @(negedge clk);
        rst_n = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 12'h008, '0);
        drive(1'b1, 1'b1, 1'b0, 12'hFFC, '0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("mrst_tie_p0", {ack1, ack0}, 2'b01);
        req0 = 1'b0;
        req1 = 1'b0;
        tick();

        // Randomized run against a transaction-level model
        begin
            int ne, g, free_at;
            logic gp, gwe, gknown, last, w;
            logic [3:0] gaddr;
            logic [DW-1:0] gexp, gdata;
            reset_pulse();
            ne = 0; g = -100; free_at = 0; last = 1'b1;
            gp = 0; gwe = 0; gknown = 0; gaddr = '0; gexp = '0; gdata = '0;
            for (int i = 0; i < 16; i++) known[i] = 1'b0;
            p_act[0] = 0; p_act[1] = 0;
            for (int n = 0; n < 3000; n++) begin
                chk("rnd_ack0", ack0, (ne == g + 1) && !gp);
                chk("rnd_ack1", ack1, (ne == g + 1) && gp);
                chk("rnd_busy", busy, (ne == g) || (ne == g + 1));
                chk("rnd_mem_read", mem_read, (ne == g) && !gwe);
                chk("rnd_mem_write", mem_write, (ne == g) && gwe);
                if (ne == g) chk("rnd_mem_addr", mem_addr, {6'd0, gaddr});
                if (ne == g && gwe) chk("rnd_mem_wdata", mem_wdata, gdata);
                if (ne == g + 1 && !gwe && gknown) chk("rnd_rdata", rdata, gexp);
                if (ne == g + 1) p_act[gp] = 1'b0;
                for (int p = 0; p < 2; p++) begin
                    if (!p_act[p] && $urandom_range(2) == 0) begin
                        p_act[p] = 1'b1;
                        p_we[p] = $urandom_range(1);
                        p_addr[p] = {6'd0, 4'($urandom_range(15)), 2'($urandom_range(3))};
                        p_data[p] = $urandom;
                    end
                    drive(p[0], p_act[p], p_we[p], p_addr[p], p_data[p]);
                end
                if (ne + 1 >= free_at && (p_act[0] || p_act[1])) begin
                    w = (p_act[0] && p_act[1]) ? !last : p_act[1];
                    g = ne + 1;
                    free_at = g + 3;
                    last = w;
                    gp = w;
                    gwe = p_we[w];
                    gaddr = p_addr[w][5:2];
                    gdata = p_data[w];
                    if (gwe) begin
                        ref_mem[gaddr] = gdata;
                        known[gaddr] = 1'b1;
                    end else begin
                        gexp = ref_mem[gaddr];
                        gknown = known[gaddr];
                    end
                end
                tick();
                ne++;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
